// File: rtl/song_sequencer.sv
// Playback controller for the 4-song ROM bank: address sequencing, song selection, pause/skip.
// Optional inter-song silence enabled by defining SEQ_GAP_EN.
module song_sequencer #(
    parameter int ADDR_W    = 11,
    parameter int IDX_W     = 2,
    parameter int LEN0      = 270,
    parameter int LEN1      = 220,
    parameter int LEN2      = 260,
    parameter int LEN3      = 260,
    parameter int GAP_TICKS = 48
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              tick_en,
    input  logic              pause,
    input  logic [2:0]        mode,
    input  logic [2:0]        choice,
    input  logic [2:0]        rand_idx,
    input  logic              skip,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [IDX_W-1:0]  song_idx,
    output logic              sample_valid,
    output logic              song_done,
    output logic              playing
);

    localparam int NUM_SONGS = 2 ** IDX_W;

`ifdef SEQ_GAP_EN
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_PLAY, S_GAP} state_t;
    logic [GAP_W-1:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_PLAY} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [IDX_W-1:0]  song_idx_q, song_idx_d;
    logic              sample_valid_q, sample_valid_d;
    logic              song_done_q, song_done_d;
    logic              playing_q, playing_d;
    logic              first_q, first_d;
    logic [2:0]        mode_q, mode_d;
    logic [2:0]        choice_q, choice_d;

    logic [ADDR_W-1:0] last_addr;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  rand_low;
    logic              reselect;
    logic              unused_rand;

    assign rand_low    = rand_idx[IDX_W-1:0];
    assign unused_rand = ^rand_idx[2:IDX_W];

    always_comb begin
        case (int'(song_idx_q))
            0:       last_addr = ADDR_W'(LEN0 - 1);
            1:       last_addr = ADDR_W'(LEN1 - 1);
            2:       last_addr = ADDR_W'(LEN2 - 1);
            default: last_addr = ADDR_W'(LEN3 - 1);
        endcase
    end

    always_comb begin
        case (mode)
            3'd0:    sel_idx = first_q ? '0 : song_idx_q + 1'b1;
            3'd1:    sel_idx = (rand_low == song_idx_q) ? rand_low + 1'b1 : rand_low;
            default: sel_idx = (choice < 3'(NUM_SONGS)) ? choice[IDX_W-1:0] : '0;
        endcase
    end

    // Settings latched at SELECT; any later difference forces a fresh selection.
    assign reselect = (mode != mode_q) || (mode == 3'd2 && choice != choice_q);

    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        song_idx_d     = song_idx_q;
        sample_valid_d = 1'b0;
        song_done_d    = 1'b0;
        first_d        = first_q;
        mode_d         = mode_q;
        choice_d       = choice_q;
`ifdef SEQ_GAP_EN
        gap_d          = gap_q;
`endif
        if (mode > 3'd2) begin
            state_d    = S_IDLE;
            rom_addr_d = '0;
            first_d    = 1'b1;
        end else if (!pause) begin
            case (state_q)
                S_IDLE: state_d = S_SELECT;
                S_SELECT: begin
                    rom_addr_d = '0;
                    song_idx_d = sel_idx;
                    first_d    = 1'b0;
                    mode_d     = mode;
                    choice_d   = choice;
                    state_d    = S_PLAY;
                end
                S_PLAY: begin
                    if (reselect) begin
                        state_d = S_SELECT;
                    end else if (tick_en || skip) begin
                        sample_valid_d = tick_en;
                        if (skip || rom_addr_q == last_addr) begin
                            song_done_d = 1'b1;
                            rom_addr_d  = '0;
`ifdef SEQ_GAP_EN
                            gap_d       = '0;
                            state_d     = S_GAP;
`else
                            state_d     = S_SELECT;
`endif
                        end else begin
                            rom_addr_d = rom_addr_q + 1'b1;
                        end
                    end
                end
`ifdef SEQ_GAP_EN
                S_GAP: begin
                    if (reselect || skip) begin
                        state_d = S_SELECT;
                    end else if (tick_en) begin
                        if (gap_q == GAP_W'(GAP_TICKS - 1)) state_d = S_SELECT;
                        else gap_d = gap_q + 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        playing_d = (state_d == S_PLAY);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q        <= S_IDLE;
            rom_addr_q     <= '0;
            song_idx_q     <= '0;
            sample_valid_q <= 1'b0;
            song_done_q    <= 1'b0;
            playing_q      <= 1'b0;
            first_q        <= 1'b1;
            mode_q         <= '0;
            choice_q       <= '0;
`ifdef SEQ_GAP_EN
            gap_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            song_idx_q     <= song_idx_d;
            sample_valid_q <= sample_valid_d;
            song_done_q    <= song_done_d;
            playing_q      <= playing_d;
            first_q        <= first_d;
            mode_q         <= mode_d;
            choice_q       <= choice_d;
`ifdef SEQ_GAP_EN
            gap_q          <= gap_d;
`endif
        end
    end

    assign rom_addr     = rom_addr_q;
    assign song_idx     = song_idx_q;
    assign sample_valid = sample_valid_q;
    assign song_done    = song_done_q;
    assign playing      = playing_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer (default build, no inter-song gap).
module tb_song_sequencer;
    localparam int LEN [4] = '{270, 220, 260, 260};

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        tick_en = 1'b0;
    logic        pause = 1'b0;
    logic        skip = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [2:0]  choice = 3'd0;
    logic [2:0]  rand_idx = 3'd0;
    logic [10:0] rom_addr;
    logic [1:0]  song_idx;
    logic        sample_valid;
    logic        song_done;
    logic        playing;

    song_sequencer dut (
        .clk          (clk),
        .clrn         (clrn),
        .tick_en      (tick_en),
        .pause        (pause),
        .mode         (mode),
        .choice       (choice),
        .rand_idx     (rand_idx),
        .skip         (skip),
        .rom_addr     (rom_addr),
        .song_idx     (song_idx),
        .sample_valid (sample_valid),
        .song_done    (song_done),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sv [$];
    int exp_done [$];
    int m_idx = 0;
    int m_addr = 0;
    bit m_first = 1'b1;
    int last_obs = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs sampled on the falling edge; a sample pulse refers to the address seen one cycle earlier.
    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_sv.size() == 0) check("sample_unexpected", last_obs, -1);
            else check("sample", last_obs, exp_sv.pop_front());
        end
        if (song_done) begin
            if (exp_done.size() == 0) check("done_unexpected", int'(song_idx), -1);
            else check("done_idx", int'(song_idx), exp_done.pop_front());
        end
        last_obs = int'(song_idx) * 4096 + int'(rom_addr);
    end

    function automatic int model_sel(input bit first);
        int r;
        case (mode)
            3'd0: return first ? 0 : (m_idx + 1) % 4;
            3'd1: begin
                r = int'(rand_idx) % 4;
                return (r == m_idx) ? (r + 1) % 4 : r;
            end
            default: return (choice < 3'd4) ? int'(choice) : 0;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input bit tk, input bit sk);
        @(negedge clk);
        tick_en = tk;
        skip    = sk;
        if (!pause) begin
            if (tk) exp_sv.push_back(m_idx * 4096 + m_addr);
            if (sk || (tk && m_addr == LEN[m_idx] - 1)) begin
                exp_done.push_back(m_idx);
                m_addr = 0;
                m_idx  = model_sel(1'b0);
            end else if (tk) begin
                m_addr++;
            end
        end
        @(negedge clk);
        tick_en = 1'b0;
        skip    = 1'b0;
        cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0);
    endtask

    task automatic set_mode(input logic [2:0] m, input logic [2:0] c);
        @(negedge clk);
        mode   = m;
        choice = c;
        if (m <= 3'd2) begin
            m_idx   = model_sel(m_first);
            m_first = 1'b0;
            m_addr  = 0;
        end else begin
            m_first = 1'b1;
            m_addr  = 0;
        end
        cyc(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, int'(rom_addr), 0);
        check({tag, "_idx"}, int'(song_idx), 0);
        check({tag, "_sv"}, int'(sample_valid), 0);
        check({tag, "_done"}, int'(song_done), 0);
        check({tag, "_playing"}, int'(playing), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        clrn = 1'b1;
        m_idx = 0; m_addr = 0; m_first = 1'b0;
        cyc(3);
        check("start_idx", int'(song_idx), 0);
        check("start_playing", int'(playing), 1);

        // Song 0 with a pause at address 100
        ticks(100);
        check("pre_pause_addr", int'(rom_addr), 100);
        pause = 1'b1;
        ticks(20);
        step(1'b0, 1'b1);
        check("paused_addr", int'(rom_addr), 100);
        check("paused_playing", int'(playing), 1);
        pause = 1'b0;
        ticks(1);
        check("resume_addr", int'(rom_addr), 101);
        ticks(LEN[0] - 101);
        check("done0_consumed", exp_done.size(), 0);
        check("song1_idx", int'(song_idx), 1);

        for (int s = 1; s < 4; s++) begin
            ticks(LEN[s]);
            check("done_consumed", exp_done.size(), 0);
            check("order_idx", int'(song_idx), (s + 1) % 4);
        end
        check("order_addr", int'(rom_addr), 0);

        // Random mode: upper bit ignored, repeat of current song avoided
        rand_idx = 3'd6;
        set_mode(3'd1, 3'd0);
        check("rand_idx", int'(song_idx), 2);
        rand_idx = 3'd2;
        ticks(LEN[2]);
        check("rand_norepeat", int'(song_idx), 3);

        // Chosen mode
        set_mode(3'd2, 3'd5);
        check("choice_oob", int'(song_idx), 0);
        set_mode(3'd2, 3'd1);
        check("choice1", int'(song_idx), 1);
        ticks(50);
        check("choice1_addr", int'(rom_addr), 50);
        set_mode(3'd2, 3'd3);
        check("choice3_idx", int'(song_idx), 3);
        check("choice3_addr", int'(rom_addr), 0);
        ticks(10);
        step(1'b0, 1'b1);
        check("skip_addr", int'(rom_addr), 0);
        check("skip_idx", int'(song_idx), 3);
        ticks(LEN[3] - 1);
        check("last_addr", int'(rom_addr), LEN[3] - 1);
        step(1'b1, 1'b1);
        check("skiplast_done_q", exp_done.size(), 0);
        check("skiplast_sv_q", exp_sv.size(), 0);

        // Idle via invalid mode
        set_mode(3'd5, 3'd0);
        check("idle_playing", int'(playing), 0);
        check("idle_addr", int'(rom_addr), 0);

        // Reset in the middle of song 2
        set_mode(3'd0, 3'd0);
        check("reentry_idx", int'(song_idx), 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("skip2_idx", int'(song_idx), 2);
        ticks(150);
        check("mid_addr", int'(rom_addr), 150);
        @(negedge clk);
        #2 clrn = 1'b0;
        #1 check_reset_outputs("async");
        @(negedge clk);
        clrn = 1'b1;
        m_idx = 0; m_addr = 0; m_first = 1'b0;
        cyc(3);
        check("restart_idx", int'(song_idx), 0);
        check("restart_playing", int'(playing), 1);
        ticks(5);
        check("restart_addr", int'(rom_addr), 5);
        cyc(2);
        check("final_sv_q", exp_sv.size(), 0);
        check("final_done_q", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
